// File: rtl/serial_pad_encoder.sv
`default_nettype none
// ============================================================================
// Module   : serial_pad_encoder
// Function : multi-channel console pad shift-out encoder (SNES/3DO style);
//            optional stall watchdog via SERIAL_PAD_ENCODER_WATCHDOG_EN
// Revision : 1.0 - initial release
// ============================================================================
module serial_pad_encoder #(
  parameter int   WIDTH             = 16,
  parameter int   NUM_CH            = 1,
  parameter int   SYNC_STAGES       = 2,
  parameter int   LATCH_ACTIVE_HIGH = 1,
  parameter int   CLK_RISING        = 1,
  parameter logic FILL_BIT          = 1'b1,
  parameter int   WDT_CYCLES        = 65535
) (
  input  logic                           system_clock,
  input  logic                           system_reset_n,
  input  logic [NUM_CH*WIDTH-1:0]        i,
  input  logic                           pad_latch,
  input  logic                           pad_clk,
  output logic [NUM_CH-1:0]              pad_data,
  output logic                           frame_done,
  output logic [$clog2(WIDTH+1)-1:0]     bit_count,
  output logic                           wdt_timeout
);

  localparam int              c_cw       = $clog2(WIDTH + 1);
  localparam logic            c_latch_on = (LATCH_ACTIVE_HIGH != 0);
  localparam logic            c_latch_off = (LATCH_ACTIVE_HIGH == 0);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(WIDTH - 1);
  localparam logic [c_cw-1:0] c_cnt_full = c_cw'(WIDTH);
  localparam logic [NUM_CH-1:0] c_fill_all = {NUM_CH{FILL_BIT}};

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic                   latch_hist_q, latch_hist_d;
  logic                   clk_hist_q, clk_hist_d;
  logic [1:0]             state_q, state_d;
  // Bit 0 of each frame lives in pad_data; the shadow holds bits WIDTH-1..1.
  logic [NUM_CH-1:0][WIDTH-2:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]      pad_data_q, pad_data_d;
  logic [c_cw-1:0]        bit_count_q, bit_count_d;
  logic                   frame_done_q, frame_done_d;

  logic                   w_latch_lvl;
  logic                   w_latch_act;
  logic                   w_latch_rel;
  logic                   w_clk_edge;
  logic [NUM_CH-1:0][WIDTH-1:0] w_shift;

`ifdef SERIAL_PAD_ENCODER_WATCHDOG_EN
  localparam int                 c_wdt_w    = $clog2(WDT_CYCLES + 1);
  localparam logic [c_wdt_w-1:0] c_wdt_last = c_wdt_w'(WDT_CYCLES - 1);
  localparam logic [c_wdt_w-1:0] c_wdt_one  = c_wdt_w'(1);
  logic [c_wdt_w-1:0] wdt_cnt_q, wdt_cnt_d;
  logic               wdt_timeout_q, wdt_timeout_d;
`endif

  always_comb begin
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], pad_latch};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
    latch_hist_d = latch_sync_q[SYNC_STAGES-1];
    clk_hist_d   = clk_sync_q[SYNC_STAGES-1];
  end

  assign w_latch_lvl = (latch_sync_q[SYNC_STAGES-1] == c_latch_on);
  assign w_latch_act = w_latch_lvl & (latch_hist_q != c_latch_on);
  assign w_latch_rel = ~w_latch_lvl & (latch_hist_q == c_latch_on);

  generate
    if (CLK_RISING != 0) begin : g_clk_rise
      assign w_clk_edge = clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
    end else begin : g_clk_fall
      assign w_clk_edge = ~clk_sync_q[SYNC_STAGES-1] & clk_hist_q;
    end
  endgenerate

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_shift
      assign w_shift[g] = {FILL_BIT, shadow_q[g]};
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pad_data_d   = pad_data_q;
    bit_count_d  = bit_count_q;
    frame_done_d = 1'b0;
`ifdef SERIAL_PAD_ENCODER_WATCHDOG_EN
    wdt_cnt_d     = '0;
    wdt_timeout_d = 1'b0;
`endif
    // A fresh latch always restarts the frame, even mid-shift or on a clock edge.
    if (w_latch_act) begin
      state_d     = c_st_load;
      bit_count_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_d[c]   = i[c*WIDTH+1 +: WIDTH-1];
        pad_data_d[c] = i[c*WIDTH];
      end
    end else begin
      case (state_q)
        c_st_idle: begin
          pad_data_d = c_fill_all;
        end
        c_st_load: begin
          bit_count_d = '0;
          if (w_latch_rel) begin
            state_d = c_st_shift;
          end else if (w_latch_lvl) begin
            for (int c = 0; c < NUM_CH; c++) begin
              shadow_d[c]   = i[c*WIDTH+1 +: WIDTH-1];
              pad_data_d[c] = i[c*WIDTH];
            end
          end
        end
        c_st_shift: begin
          if (w_clk_edge) begin
            for (int c = 0; c < NUM_CH; c++) begin
              shadow_d[c]   = w_shift[c][WIDTH-1:1];
              pad_data_d[c] = w_shift[c][0];
            end
            bit_count_d = bit_count_q + c_cnt_one;
            if (bit_count_q == c_cnt_last) begin
              pad_data_d   = c_fill_all;
              bit_count_d  = c_cnt_full;
              frame_done_d = 1'b1;
              state_d      = c_st_done;
            end
          end
`ifdef SERIAL_PAD_ENCODER_WATCHDOG_EN
          else if (wdt_cnt_q == c_wdt_last) begin
            state_d       = c_st_idle;
            pad_data_d    = c_fill_all;
            bit_count_d   = '0;
            wdt_timeout_d = 1'b1;
          end else begin
            wdt_cnt_d = wdt_cnt_q + c_wdt_one;
          end
`endif
        end
        c_st_done: begin
          pad_data_d = c_fill_all;
        end
        default: begin
          state_d = c_st_idle;
        end
      endcase
    end
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      latch_sync_q <= {SYNC_STAGES{c_latch_off}};
      clk_sync_q   <= '1;
      latch_hist_q <= c_latch_off;
      clk_hist_q   <= 1'b1;
      state_q      <= c_st_idle;
      shadow_q     <= {(NUM_CH*(WIDTH-1)){FILL_BIT}};
      pad_data_q   <= c_fill_all;
      bit_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      latch_sync_q <= latch_sync_d;
      clk_sync_q   <= clk_sync_d;
      latch_hist_q <= latch_hist_d;
      clk_hist_q   <= clk_hist_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pad_data_q   <= pad_data_d;
      bit_count_q  <= bit_count_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SERIAL_PAD_ENCODER_WATCHDOG_EN
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wdt_cnt_q     <= '0;
      wdt_timeout_q <= 1'b0;
    end else begin
      wdt_cnt_q     <= wdt_cnt_d;
      wdt_timeout_q <= wdt_timeout_d;
    end
  end

  assign wdt_timeout = wdt_timeout_q;
`else
  // Without the watchdog WDT_CYCLES is meaningless; this expression is constant 0.
  assign wdt_timeout = (WDT_CYCLES < 0);
`endif

  assign pad_data   = pad_data_q;
  assign frame_done = frame_done_q;
  assign bit_count  = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pad_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pad_encoder
// Function : self-checking bench for serial_pad_encoder (three configurations)
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pad_encoder;

  localparam int PH = 8;

  typedef struct {
    logic [15:0] word;
    logic [15:0] stream;     // transmission order: stream[15] is sent first
    int          change_at;  // clock number before which i is replaced (0: never)
    logic [15:0] new_word;
  } vec_t;

  logic clk;
  logic rst_n;
  logic rst_c_n;

  logic [15:0] a_i;
  logic        a_latch, a_pclk;
  logic [0:0]  a_pad;
  logic        a_done, a_wdt;
  logic [4:0]  a_bc;

  logic [23:0] b_i;
  logic        b_latch, b_pclk;
  logic [1:0]  b_pad;
  logic        b_done, b_wdt;
  logic [3:0]  b_bc;

  logic [15:0] c_i;
  logic        c_latch, c_pclk;
  logic [0:0]  c_pad;
  logic        c_done, c_wdt;
  logic [4:0]  c_bc;

  int n_tests = 0;
  int n_fail  = 0;
  int a_done_n = 0;
  int a_wdt_n  = 0;
  int b_done_n = 0;
  int c_done_n = 0;

  logic [1:0] sb[$];
  vec_t       vecs[6];

  serial_pad_encoder #(.WDT_CYCLES(100)) u_dut_a (
    .system_clock(clk), .system_reset_n(rst_n), .i(a_i),
    .pad_latch(a_latch), .pad_clk(a_pclk), .pad_data(a_pad),
    .frame_done(a_done), .bit_count(a_bc), .wdt_timeout(a_wdt)
  );

  serial_pad_encoder #(.WIDTH(12), .NUM_CH(2)) u_dut_b (
    .system_clock(clk), .system_reset_n(rst_n), .i(b_i),
    .pad_latch(b_latch), .pad_clk(b_pclk), .pad_data(b_pad),
    .frame_done(b_done), .bit_count(b_bc), .wdt_timeout(b_wdt)
  );

  serial_pad_encoder #(.LATCH_ACTIVE_HIGH(0), .CLK_RISING(0), .FILL_BIT(1'b0)) u_dut_c (
    .system_clock(clk), .system_reset_n(rst_c_n), .i(c_i),
    .pad_latch(c_latch), .pad_clk(c_pclk), .pad_data(c_pad),
    .frame_done(c_done), .bit_count(c_bc), .wdt_timeout(c_wdt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_done) a_done_n <= a_done_n + 1;
    if (a_wdt)  a_wdt_n  <= a_wdt_n + 1;
    if (b_done) b_done_n <= b_done_n + 1;
    if (c_done) c_done_n <= c_done_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [1:0] act);
    logic [1:0] e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", name, act, e);
      end
    end
  endtask

  task automatic a_frame(input vec_t v);
    int d0;
    d0      = a_done_n;
    a_i     = v.word;
    a_latch = 1'b1;
    sb.push_back({1'b0, v.stream[15]});
    tick(PH);
    sb_check("A load bit0", {1'b0, a_pad});
    a_latch = 1'b0;
    tick(PH);
    check("A bit_count after latch", a_bc, 0);
    for (int k = 1; k <= 17; k++) begin
      if (k == v.change_at) a_i = v.new_word;
      a_pclk = 1'b0;
      tick(PH);
      a_pclk = 1'b1;
      sb.push_back({1'b0, (k < 16) ? v.stream[15-k] : 1'b1});
      tick(PH);
      sb_check($sformatf("A word %h bit %0d", v.word, k), {1'b0, a_pad});
      if (k == 16) begin
        check("A frame_done count", a_done_n, d0 + 1);
        check("A bit_count full", a_bc, 16);
      end
    end
    check("A frame_done after extra clock", a_done_n, d0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         d0;
    int         w0;
    logic [11:0] ch0w, ch1w;
    logic [1:0]  prev, expv;
    logic [15:0] cs;

    vecs[0] = '{word: 16'hA5C3, stream: 16'hC3A5, change_at: 0, new_word: 16'h0000};
    vecs[1] = '{word: 16'h1234, stream: 16'h2C48, change_at: 0, new_word: 16'h0000};
    vecs[2] = '{word: 16'h0001, stream: 16'h8000, change_at: 0, new_word: 16'h0000};
    vecs[3] = '{word: 16'h8000, stream: 16'h0001, change_at: 0, new_word: 16'h0000};
    vecs[4] = '{word: 16'hFFFF, stream: 16'hFFFF, change_at: 4, new_word: 16'h0000};
    vecs[5] = '{word: 16'h0000, stream: 16'h0000, change_at: 0, new_word: 16'h0000};

    rst_n = 1'b0; rst_c_n = 1'b0;
    a_i = 16'h0; a_latch = 1'b0; a_pclk = 1'b1;
    b_i = 24'h0; b_latch = 1'b0; b_pclk = 1'b1;
    c_i = 16'h0; c_latch = 1'b1; c_pclk = 1'b1;
    tick(3);
    check("A reset pad_data", a_pad, 1);
    check("A reset bit_count", a_bc, 0);
    check("A reset frame_done", a_done, 0);
    check("A reset wdt_timeout", a_wdt, 0);
    check("B reset pad_data", b_pad, 2'b11);
    check("C reset pad_data", c_pad, 0);
    rst_n = 1'b1; rst_c_n = 1'b1;
    tick(3);

    for (int v = 0; v < 6; v++) a_frame(vecs[v]);

    // Latency from latch pin to pad_data, then latch colliding with a clock edge.
    a_i = 16'hFFFE;
    a_latch = 1'b1;
    tick(2);
    check("A latency before", a_pad, 1);
    tick(1);
    check("A latency at 3 cycles", a_pad, 0);
    tick(PH - 3);
    a_latch = 1'b0;
    tick(PH);
    for (int k = 1; k <= 5; k++) begin
      a_pclk = 1'b0; tick(PH); a_pclk = 1'b1; tick(PH);
    end
    check("A bit_count before collision", a_bc, 5);
    d0 = a_done_n;
    a_pclk = 1'b0;
    tick(PH);
    a_i = 16'h0002;
    a_latch = 1'b1;
    a_pclk = 1'b1;
    tick(PH);
    check("A collision bit_count", a_bc, 0);
    check("A collision pad_data", a_pad, 0);
    check("A collision no frame_done", a_done_n, d0);
    a_latch = 1'b0;
    tick(PH);

    // Stall after three clocks.
    a_i = 16'h0004;
    a_latch = 1'b1; tick(PH); a_latch = 1'b0; tick(PH);
    for (int k = 1; k <= 3; k++) begin
      a_pclk = 1'b0; tick(PH); a_pclk = 1'b1;
      if (k < 3) tick(PH);
    end
    tick(2);
    check("A stall pre-edge3 pad", a_pad, 1);
    tick(1);
    check("A stall edge3 pad", a_pad, 0);
    w0 = a_wdt_n;
    tick(99);
    check("A wdt not early", a_wdt, 0);
    check("A wdt count not early", a_wdt_n, w0);
    tick(1);
`ifdef SERIAL_PAD_ENCODER_WATCHDOG_EN
    check("A wdt pulse", a_wdt, 1);
    check("A wdt bit_count", a_bc, 0);
    check("A wdt pad_data", a_pad, 1);
    tick(1);
    check("A wdt pulse width", a_wdt, 0);
    check("A wdt pulse count", a_wdt_n, w0 + 1);
`else
    check("A no wdt pulse", a_wdt, 0);
    check("A stall bit_count", a_bc, 3);
    check("A stall pad_data", a_pad, 0);
    tick(1);
    check("A no wdt pulse count", a_wdt_n, w0);
`endif

    // Two channels, width 12: both lines must change on the same cycle.
    ch0w = 12'hABC; ch1w = 12'h0F0;
    b_i = {ch1w, ch0w};
    d0 = b_done_n;
    b_latch = 1'b1;
    sb.push_back({ch1w[0], ch0w[0]});
    tick(PH);
    sb_check("B load bit0", b_pad);
    b_latch = 1'b0;
    tick(PH);
    prev = {ch1w[0], ch0w[0]};
    for (int k = 1; k <= 12; k++) begin
      b_pclk = 1'b0; tick(PH); b_pclk = 1'b1;
      expv = (k < 12) ? {ch1w[k], ch0w[k]} : 2'b11;
      sb.push_back(expv);
      tick(2);
      check($sformatf("B hold before clock %0d", k), b_pad, prev);
      tick(1);
      sb_check($sformatf("B bit %0d", k), b_pad);
      prev = expv;
      tick(PH - 3);
    end
    check("B frame_done count", b_done_n, d0 + 1);
    check("B bit_count full", b_bc, 12);
    check("B wdt idle", b_wdt, 0);

    // Active-low latch, falling-edge clock, fill 0.
    c_i = 16'h5A3C; cs = 16'h3C5A;
    d0 = c_done_n;
    c_latch = 1'b0;
    sb.push_back({1'b0, cs[15]});
    tick(PH);
    sb_check("C load bit0", {1'b0, c_pad});
    c_latch = 1'b1;
    tick(PH);
    for (int k = 1; k <= 17; k++) begin
      c_pclk = 1'b0;
      sb.push_back({1'b0, (k < 16) ? cs[15-k] : 1'b0});
      tick(PH);
      sb_check($sformatf("C bit %0d", k), {1'b0, c_pad});
      c_pclk = 1'b1;
      tick(PH);
    end
    check("C frame_done count", c_done_n, d0 + 1);
    check("C bit_count full", c_bc, 16);

    // Asynchronous reset mid-frame.
    c_i = 16'hFFFF;
    c_latch = 1'b0; tick(PH); c_latch = 1'b1; tick(PH);
    for (int k = 1; k <= 3; k++) begin
      c_pclk = 1'b0; tick(PH); c_pclk = 1'b1; tick(PH);
    end
    check("C mid-frame pad", c_pad, 1);
    check("C mid-frame bit_count", c_bc, 3);
    d0 = c_done_n;
    rst_c_n = 1'b0;
    #1;
    check("C async reset pad", c_pad, 0);
    check("C async reset bit_count", c_bc, 0);
    tick(2);
    rst_c_n = 1'b1;
    tick(PH);
    c_pclk = 1'b0; tick(PH);
    check("C no frame without latch pad", c_pad, 0);
    check("C no frame without latch count", c_bc, 0);
    c_pclk = 1'b1; tick(PH);
    c_latch = 1'b0; tick(PH);
    check("C fresh latch pad", c_pad, 1);
    c_latch = 1'b1; tick(PH);
    check("C no frame_done across reset", c_done_n, d0);
    check("C wdt idle", c_wdt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
